// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters with horizontal and vertical phase FSMs.
// All outputs decode registered state only; EN gates every state update.
module vga_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       EN,
   output logic [9:0] COL,
   output logic [9:0] ROW,
   output logic       ACTIVE,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       LINE_START,
   output logic       FRAME_START
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Last count of each phase; the phase changes on the edge leaving it.
   localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE - 1);
   localparam logic [9:0] H_FP_END  = 10'(H_ACTIVE + H_FRONT - 1);
   localparam logic [9:0] H_SYN_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
   localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FRONT - 1);
   localparam logic [9:0] V_SYN_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

   // One-hot so that corrupted encodings are detectable and recoverable.
   typedef enum logic [3:0] {
      H_ACT = 4'b0001,
      H_FP  = 4'b0010,
      H_SYN = 4'b0100,
      H_BP  = 4'b1000
   } h_state_t;

   typedef enum logic [3:0] {
      V_ACT = 4'b0001,
      V_FP  = 4'b0010,
      V_SYN = 4'b0100,
      V_BP  = 4'b1000
   } v_state_t;

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   h_state_t   h_state_q, h_state_d;
   v_state_t   v_state_q, v_state_d;
   logic       h_wrap, v_wrap, state_ok;

   always_comb begin
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      h_state_d = h_state_q;
      v_state_d = v_state_q;
      h_wrap    = (h_cnt_q == H_LAST);
      v_wrap    = (v_cnt_q == V_LAST);
      state_ok  = (h_state_q inside {H_ACT, H_FP, H_SYN, H_BP}) &&
                  (v_state_q inside {V_ACT, V_FP, V_SYN, V_BP});

      if (!state_ok) begin
         h_cnt_d   = '0;
         v_cnt_d   = '0;
         h_state_d = H_ACT;
         v_state_d = V_ACT;
      end else if (EN) begin
         h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
         case (h_state_q)
            H_ACT:   if (h_cnt_q == H_ACT_END) h_state_d = H_FP;
            H_FP:    if (h_cnt_q == H_FP_END)  h_state_d = H_SYN;
            H_SYN:   if (h_cnt_q == H_SYN_END) h_state_d = H_BP;
            H_BP:    if (h_wrap)               h_state_d = H_ACT;
            default: h_state_d = H_ACT;
         endcase

         // Vertical side only moves on the edge that ends a line.
         if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            case (v_state_q)
               V_ACT:   if (v_cnt_q == V_ACT_END) v_state_d = V_FP;
               V_FP:    if (v_cnt_q == V_FP_END)  v_state_d = V_SYN;
               V_SYN:   if (v_cnt_q == V_SYN_END) v_state_d = V_BP;
               V_BP:    if (v_wrap)               v_state_d = V_ACT;
               default: v_state_d = V_ACT;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         h_state_q <= H_ACT;
         v_state_q <= V_ACT;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         h_state_q <= h_state_d;
         v_state_q <= v_state_d;
      end
   end

   assign COL         = h_cnt_q;
   assign ROW         = v_cnt_q;
   assign ACTIVE      = (h_state_q == H_ACT) && (v_state_q == V_ACT);
   assign HSYNC       = (h_state_q != H_SYN);
   assign VSYNC       = (v_state_q != V_SYN);
   assign LINE_START  = (h_cnt_q == '0);
   assign FRAME_START = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized/directed bench for vga_timing_ctrl; the reference derives the raster
// position from the number of enabled edges. Vertical sizes are shrunk to keep frames short.
module tb_vga_timing_ctrl;

   localparam int HA = 640, HF = 16, HS = 96, HB = 48;
   localparam int VA = 20,  VF = 3,  VS = 2,  VB = 5;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic       CLK, RST_N, EN;
   logic [9:0] COL, ROW;
   logic       ACTIVE, HSYNC, VSYNC, LINE_START, FRAME_START;

   int n, checks, fails;

   vga_timing_ctrl #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN),
      .COL(COL), .ROW(ROW), .ACTIVE(ACTIVE), .HSYNC(HSYNC), .VSYNC(VSYNC),
      .LINE_START(LINE_START), .FRAME_START(FRAME_START)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, obs, exp, n);
      end
   endtask

   // Reference: position is simply the enabled-edge count folded into the raster.
   task automatic check_all();
      int c, r;
      c = n % HT;
      r = (n / HT) % VT;
      chk("COL", COL, c);
      chk("ROW", ROW, r);
      chk("ACTIVE", ACTIVE, (c < HA && r < VA) ? 1 : 0);
      chk("HSYNC", HSYNC, (c >= HA + HF && c < HA + HF + HS) ? 0 : 1);
      chk("VSYNC", VSYNC, (r >= VA + VF && r < VA + VF + VS) ? 0 : 1);
      chk("LINE_START", LINE_START, (c == 0) ? 1 : 0);
      chk("FRAME_START", FRAME_START, (c == 0 && r == 0) ? 1 : 0);
   endtask

   task automatic tick(input bit en);
      EN = en;
      @(posedge CLK);
      #1;
      if (en) n++;
      check_all();
   endtask

   // r < 0 means any row.
   task automatic advance_to(input int c, input int r);
      int k;
      k = 0;
      while (!((n % HT) == c && (r < 0 || ((n / HT) % VT) == r)) && k < 40000) begin
         tick(1'b1);
         k++;
      end
      chk("advance_bound", (k < 40000) ? 1 : 0, 1);
   endtask

   initial begin
      int hs_low, vs_low, ls_cnt, fs_cnt, act_cnt;
      checks = 0;
      fails  = 0;
      n      = 0;
      RST_N  = 1'b0;
      EN     = 1'b0;

      // Held in reset: EN must not matter.
      repeat (3) begin
         EN = 1'($urandom_range(0, 1));
         @(posedge CLK);
         #1;
         check_all();
      end
      RST_N = 1'b1;

      // One line from release: first edge gives COL=1.
      hs_low = 0; ls_cnt = 0; act_cnt = 0;
      for (int i = 0; i < HT; i++) begin
         tick(1'b1);
         if (i == 0) chk("first_col", COL, 1);
         if (!HSYNC) hs_low++;
         if (LINE_START) ls_cnt++;
         if (ACTIVE) act_cnt++;
      end
      chk("line_hsync_low", hs_low, HS);
      chk("line_start_cnt", ls_cnt, 1);
      chk("line_active_cnt", act_cnt, HA);

      // One full frame from a frame start.
      advance_to(0, 0);
      vs_low = 0; fs_cnt = 0;
      for (int i = 0; i < HT * VT; i++) begin
         tick(1'b1);
         if (!VSYNC) vs_low++;
         if (FRAME_START) fs_cnt++;
      end
      chk("frame_vsync_low", vs_low, VS * HT);
      chk("frame_start_cnt", fs_cnt, 1);
      chk("frame_end_row", ROW, 0);

      // Stall just before sync.
      advance_to(655, -1);
      repeat (50) tick(1'b0);
      chk("stall_col", COL, 655);
      chk("stall_hsync", HSYNC, 1);
      tick(1'b1);
      chk("stall_next_col", COL, 656);
      chk("stall_next_hsync", HSYNC, 0);

      repeat (3000) tick(1'($urandom_range(0, 1)));

      // Half-rate enable: a line spans twice the clocks.
      advance_to(0, -1);
      hs_low = 0; ls_cnt = 0;
      for (int i = 0; i < 2 * HT; i++) begin
         tick(1'(i % 2));
         if (!HSYNC) hs_low++;
         if (LINE_START) ls_cnt++;
      end
      chk("alt_hsync_low", hs_low, 2 * HS);
      chk("alt_line_start", ls_cnt, 2);
      chk("alt_end_col", COL, 0);

      // Asynchronous reset mid-frame, checked before the next clock edge.
      advance_to(400, 12);
      #3 RST_N = 1'b0;
      #1;
      n = 0;
      check_all();
      @(posedge CLK);
      #1;
      check_all();
      RST_N = 1'b1;
      tick(1'b1);
      chk("restart_col", COL, 1);
      repeat (HT) tick(1'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch pixels
- H_SYNC, 96, horizontal sync pixels
- H_BACK, 48, horizontal back porch pixels
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch lines
- V_SYNC, 2, vertical sync lines
- V_BACK, 33, vertical back porch lines
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- CLK, in, 1, single system clock; all state updates on its rising edge
- RST_N, in, 1, asynchronous active-low reset
- EN, in, 1, pixel-clock enable; state advances only on CLK edges with EN=1
- COL, out, 10, horizontal pixel counter h_cnt
- ROW, out, 10, vertical line counter v_cnt; drives the color-bar generator's 10-bit row address
- ACTIVE, out, 1, visible-region flag
- HSYNC, out, 1, active-low horizontal sync
- VSYNC, out, 1, active-low vertical sync
- LINE_START, out, 1, high while h_cnt==0
- FRAME_START, out, 1, high while h_cnt==0 and v_cnt==0
REQ-003 Reset SHALL be asynchronous and active-low on RST_N; the single clock SHALL be CLK.

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); it SHALL wrap to 0 after H_TOTAL-1.
REQ-005 v_cnt SHALL increment by one only on the enabled edge where h_cnt wraps; it SHALL count 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525), and SHALL wrap to 0 when both counters wrap together.
REQ-006 The horizontal FSM SHALL have states H_ACT, H_FP, H_SYN and H_BP, with these transitions:
- H_ACT->H_FP on the edge where h_cnt goes H_ACTIVE-1 -> H_ACTIVE
- H_FP->H_SYN at H_ACTIVE+H_FRONT
- H_SYN->H_BP at H_ACTIVE+H_FRONT+H_SYNC
- H_BP->H_ACT on wrap to 0
REQ-007 The vertical FSM SHALL have states V_ACT, V_FP, V_SYN and V_BP, with transitions at the same boundaries using the V_* parameters, evaluated only on h_cnt wrap edges.
REQ-008 All outputs SHALL be Moore decodes of registered state: no combinational path from EN to any output, and zero latency between COL/ROW and the flags in the same cycle.
REQ-009 Output decodes SHALL be:
- ACTIVE = 1 iff horizontal state is H_ACT and vertical state is V_ACT
- HSYNC = 0 iff horizontal state is H_SYN
- VSYNC = 0 iff vertical state is V_SYN
REQ-010 FSM states SHALL always agree with the counter ranges; a state/counter mismatch SHALL NOT be reachable from reset.
REQ-011 With EN=0, counters, states and all outputs SHALL hold their values indefinitely; LINE_START and FRAME_START SHALL remain high while stalled at their positions.
REQ-012 EN toggling every cycle SHALL halve the timing rate exactly, with no skipped or duplicated counts.
REQ-013 Undefined state encodings SHALL recover to H_ACT/V_ACT with counters at 0 on the next clock edge, regardless of EN.
REQ-014 COL and ROW SHALL be unsigned; with default parameters neither exceeds 799 or 524, respectively.

Reset
REQ-015 While RST_N=0, the block SHALL hold h_cnt=0, v_cnt=0, states H_ACT/V_ACT, COL=0, ROW=0, ACTIVE=1, HSYNC=1, VSYNC=1, LINE_START=1 and FRAME_START=1.
REQ-016 Asserting RST_N mid-line or mid-frame SHALL force the REQ-015 values immediately, without waiting for CLK.
REQ-017 The first enabled edge after release SHALL produce h_cnt=1.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset release, EN=1 -> COL steps 0,1,2...; ACTIVE=1 for COL 0..639 and 0 at 640; LINE_START high only at COL=0.
- EN=1 over one line -> HSYNC low exactly for COL 656..751 (96 cycles); 800 cycles between LINE_START pulses.
- EN=1 over one full frame -> VSYNC low exactly for ROW 490..491 (1600 cycles); FRAME_START recurs after 420000 enabled cycles; ROW wraps 524->0 with COL 799->0.
- EN held low 50 cycles at COL=655 -> all outputs frozen; the next enabled edge gives COL=656 and HSYNC=0.
- RST_N pulsed low at ROW=300, COL=400 asynchronous to CLK -> outputs reach REQ-015 values before the next CLK edge; restart matches the first scenario.
- EN alternating 1/0 -> one line spans 1600 CLK cycles; the HSYNC low width is 192 CLK cycles.
